// File: rtl/chip_pkg.sv
// rtl/chip_pkg.sv - shared types and slot indices for the chip test sequencer
package chip_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACK    = 2'd3
  } ctrl_state_t;

  localparam int NUM_CHIPS_DEF = 8;

  // Checker slot order, also used by the top-level mux and LED decode
  localparam int CHIP_7400 = 0;
  localparam int CHIP_7404 = 1;
  localparam int CHIP_7408 = 2;
  localparam int CHIP_7432 = 3;
  localparam int CHIP_7486 = 4;
  localparam int CHIP_7402 = 5;
  localparam int CHIP_7410 = 6;
  localparam int CHIP_7420 = 7;

endpackage

// File: rtl/chip_test_ctrl_if.sv
// rtl/chip_test_ctrl_if.sv - Run/Done/RSLT/DISP_RSLT handshake between sequencer and checkers
interface chip_test_ctrl_if #(
  parameter int NUM_CHIPS = 8
);
  logic [NUM_CHIPS-1:0] Chip_Done;
  logic [NUM_CHIPS-1:0] Chip_RSLT;
  logic [NUM_CHIPS-1:0] Chip_Run;
  logic                 DISP_RSLT;

  modport master (input Chip_Done, input Chip_RSLT, output Chip_Run, output DISP_RSLT);
  modport slave  (output Chip_Done, output Chip_RSLT, input Chip_Run, input DISP_RSLT);
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at all-ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/chip_test_ctrl.sv
// rtl/chip_test_ctrl.sv - one-shot checker run with timeout and tallies; CHIP_TEST_CTRL_LOOP_EN adds pass-looping
module chip_test_ctrl
  import chip_pkg::*;
#(
  parameter int NUM_CHIPS      = NUM_CHIPS_DEF,
  parameter int SEL_W          = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [SEL_W-1:0] Chip_Sel,
`ifdef CHIP_TEST_CTRL_LOOP_EN
  input  logic             Loop,
`endif
  chip_test_ctrl_if.master chk,
  output logic             Busy,
  output logic             Pass_LED,
  output logic             Fail_LED,
  output logic             Timeout_LED,
  output logic [CNT_W-1:0] Pass_Count,
  output logic [CNT_W-1:0] Fail_Count
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  ctrl_state_t          r_state;
  ctrl_state_t          w_next;
  logic                 r_start_q;
  logic [SEL_W-1:0]     r_sel;
  logic [TW-1:0]        r_tcnt;
  logic [NUM_CHIPS-1:0] r_run;
  logic                 r_disp;
  logic                 r_busy;
  logic                 r_pass_led;
  logic                 r_fail_led;
  logic                 r_tout_led;

  logic w_launch;
  logic w_sel_ok;
  logic w_done;
  logic w_rslt;
  logic w_tout;
  logic w_pass_inc;
  logic w_fail_inc;

  assign w_launch = Start & ~r_start_q;
  assign w_sel_ok = (32'(Chip_Sel) < NUM_CHIPS);
  assign w_done   = chk.Chip_Done[r_sel];
  assign w_rslt   = chk.Chip_RSLT[r_sel];
  assign w_tout   = (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

  // Done beats timeout when both land in the same Wait cycle
  assign w_pass_inc = (r_state == ST_WAIT) &  w_done &  w_rslt;
  assign w_fail_inc = (r_state == ST_WAIT) & ((w_done & ~w_rslt) | (~w_done & w_tout));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_launch && w_sel_ok) w_next = ST_LAUNCH;
      ST_LAUNCH: w_next = ST_WAIT;
      ST_WAIT: begin
        if (w_done)      w_next = ST_ACK;
        else if (w_tout) w_next = ST_IDLE;
      end
      ST_ACK: begin
`ifdef CHIP_TEST_CTRL_LOOP_EN
        w_next = (Loop && r_pass_led) ? ST_LAUNCH : ST_IDLE;
`else
        w_next = ST_IDLE;
`endif
      end
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_start_q  <= 1'b0;
      r_sel      <= '0;
      r_tcnt     <= '0;
      r_run      <= '0;
      r_disp     <= 1'b0;
      r_busy     <= 1'b0;
      r_pass_led <= 1'b0;
      r_fail_led <= 1'b0;
      r_tout_led <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_start_q <= Start;
      r_busy    <= (w_next != ST_IDLE);
      r_disp    <= (w_next == ST_ACK);
      r_run     <= (r_state == ST_LAUNCH) ? (NUM_CHIPS'(1) << r_sel) : '0;
      if (r_state == ST_IDLE && w_next == ST_LAUNCH) begin
        r_sel      <= Chip_Sel;
        r_pass_led <= 1'b0;
        r_fail_led <= 1'b0;
        r_tout_led <= 1'b0;
      end
      if (r_state == ST_LAUNCH) r_tcnt <= '0;
      if (r_state == ST_WAIT) begin
        r_tcnt <= r_tcnt + TW'(1);
        if (w_done) begin
          r_pass_led <= w_rslt;
          r_fail_led <= ~w_rslt;
        end else if (w_tout) begin
          r_fail_led <= 1'b1;
          r_tout_led <= 1'b1;
        end
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_pass_cnt (.Clk(Clk), .Reset(Reset), .inc(w_pass_inc), .q(Pass_Count));
  sat_counter #(.W(CNT_W)) u_fail_cnt (.Clk(Clk), .Reset(Reset), .inc(w_fail_inc), .q(Fail_Count));

  assign chk.Chip_Run  = r_run;
  assign chk.DISP_RSLT = r_disp;
  assign Busy          = r_busy;
  assign Pass_LED      = r_pass_led;
  assign Fail_LED      = r_fail_led;
  assign Timeout_LED   = r_tout_led;

endmodule

// File: tb/tb_chip_test_ctrl.sv
// tb/tb_chip_test_ctrl.sv - randomized bench for chip_test_ctrl with a transaction-level reference model
module tb_chip_test_ctrl;

  localparam int NC = 6;
  localparam int SW = 3;
  localparam int TO = 16;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Start = 1'b0;
  logic [SW-1:0] Chip_Sel = '0;
  logic          Loop = 1'b0;
  logic          Busy, Pass_LED, Fail_LED, Timeout_LED;
  logic [CW-1:0] Pass_Count, Fail_Count;

  chip_test_ctrl_if #(.NUM_CHIPS(NC)) bus ();

  chip_test_ctrl #(
    .NUM_CHIPS(NC), .SEL_W(SW), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Start(Start),
    .Chip_Sel(Chip_Sel),
`ifdef CHIP_TEST_CTRL_LOOP_EN
    .Loop(Loop),
`endif
    .chk(bus),
    .Busy(Busy),
    .Pass_LED(Pass_LED),
    .Fail_LED(Fail_LED),
    .Timeout_LED(Timeout_LED),
    .Pass_Count(Pass_Count),
    .Fail_Count(Fail_Count)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int m_pass = 0;
  int m_fail = 0;
  bit m_pled = 0, m_fled = 0, m_tled = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".pass_led"}, Pass_LED, m_pled);
    check({tag, ".fail_led"}, Fail_LED, m_fled);
    check({tag, ".tout_led"}, Timeout_LED, m_tled);
    check({tag, ".pass_cnt"}, Pass_Count, m_pass);
    check({tag, ".fail_cnt"}, Fail_Count, m_fail);
  endtask

  // One user test: Start edge, checker model answering dly cycles after each Run (0 = never)
  task automatic run_test(input int sel, input int dly, input bit [3:0] rs, input int hold, input bit lp);
    int runs = 0, disp = 0, run_cyc = -1, first_run = -1, busy_fall = -1, disp_cyc = -1, it = 0;
    int ncyc, exp_runs = 0, exp_disp = 0, exp_fall = -1;
    bit acked = 0, bad_pat = 0, busy_seen = 0, last_tout = 0;
    logic [NC-1:0] pat;
    logic [31:0] noise;
    pat = (sel < NC) ? (NC'(1) << sel) : '0;
    ncyc = ((hold > 10) ? hold : 10) + (lp ? 5 : 1) * (TO + 6);
    Loop = lp;
    @(posedge Clk); #1;
    Chip_Sel = SW'(sel);
    Start = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge Clk);
      if (bus.Chip_Run != '0) begin
        runs++;
        if (bus.Chip_Run !== pat) bad_pat = 1;
        run_cyc = c;
        if (first_run < 0) first_run = c;
        acked = 0;
      end
      if (bus.DISP_RSLT) begin
        disp++;
        disp_cyc = c;
        acked = 1;
        it++;
      end
      if (Busy) busy_seen = 1;
      if (first_run >= 0 && busy_fall < 0 && !Busy) busy_fall = c;
      @(posedge Clk); #1;
      if (c + 1 >= hold) Start = 1'b0;
      noise = $urandom;
      bus.Chip_Done = noise[NC-1:0];
      noise = $urandom;
      bus.Chip_RSLT = noise[NC-1:0];
      if (sel < NC) begin
        if (run_cyc >= 0 && !acked && dly > 0 && c + 1 >= run_cyc + dly) begin
          bus.Chip_Done[sel] = 1'b1;
          bus.Chip_RSLT[sel] = rs[(it > 3) ? 3 : it];
        end else begin
          bus.Chip_Done[sel] = 1'b0;
        end
      end
    end
    Start = 1'b0;
    bus.Chip_Done = '0;
    bus.Chip_RSLT = '0;

    if (sel < NC) begin
      m_pled = 0; m_fled = 0; m_tled = 0;
      for (int i = 0; i < 4; i++) begin
        exp_runs++;
        if (dly == 0 || dly >= TO) begin
          m_fled = 1; m_tled = 1;
          m_fail = (m_fail < CMAX) ? m_fail + 1 : CMAX;
          last_tout = 1;
          break;
        end
        exp_disp++;
        m_pled = rs[i]; m_fled = !rs[i];
        if (rs[i]) m_pass = (m_pass < CMAX) ? m_pass + 1 : CMAX;
        else       m_fail = (m_fail < CMAX) ? m_fail + 1 : CMAX;
        if (!(lp && rs[i])) break;
      end
    end

    check("runs", runs, exp_runs);
    check("run_onehot", bad_pat, 0);
    check("disp_pulses", disp, exp_disp);
    check("busy_seen", busy_seen, (sel < NC));
    check_state("after");
    if (sel < NC) begin
      exp_fall = last_tout ? run_cyc + TO : run_cyc + dly + 2;
      check("run_latency", first_run, 2);
      check("busy_fall", busy_fall, exp_fall);
      if (exp_disp > 0) check("disp_latency", disp_cyc, run_cyc + dly + 1);
    end
  endtask

  task automatic reset_test();
    @(posedge Clk); #1;
    Chip_Sel = 3'd1;
    Start = 1'b1;
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    check("rst.busy_in_wait", Busy, 1);
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    @(negedge Clk);
    check("rst.run", bus.Chip_Run, 0);
    check("rst.busy", Busy, 0);
    check("rst.disp", bus.DISP_RSLT, 0);
    m_pass = 0; m_fail = 0; m_pled = 0; m_fled = 0; m_tled = 0;
    check_state("rst");
    @(posedge Clk); #1;
    Reset = 1'b0;
    Start = 1'b0;
    repeat (2) @(posedge Clk);
  endtask

  initial begin
    bus.Chip_Done = '0;
    bus.Chip_RSLT = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("init.run", bus.Chip_Run, 0);
    check("init.disp", bus.DISP_RSLT, 0);
    check("init.busy", Busy, 0);
    check_state("init");
    @(posedge Clk); #1;
    Reset = 1'b0;

    run_test(1, 5, 4'b0001, 1, 0);
    run_test(1, 5, 4'b0000, 1, 0);
    run_test(2, 0, 4'b0000, 1, 0);
    run_test(3, 3, 4'b0001, 50, 0);
    run_test(7, 4, 4'b0001, 1, 0);
    run_test(6, 2, 4'b0001, 1, 0);
    run_test(4, TO - 1, 4'b0001, 2, 0);
    run_test(5, TO, 4'b0001, 1, 0);
    reset_test();

    for (int n = 0; n < 40; n++) begin
      run_test($urandom_range(0, 7), $urandom_range(0, TO + 2),
               4'($urandom_range(0, 1)), $urandom_range(1, 4), 0);
    end

    for (int n = 0; n < 260; n++) run_test(0, 1, 4'b0001, 1, 0);
    check("sat.pass", Pass_Count, CMAX);

`ifdef CHIP_TEST_CTRL_LOOP_EN
    reset_test();
    run_test(1, 3, 4'b0111, 1, 1);
    check("loop.pass", Pass_Count, 3);
    check("loop.fail", Fail_Count, 1);
    check("loop.idle", Busy, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
